// File: rtl/alu_mdu.sv
// alu_mdu: RV32I execution unit with an optional M extension.
//
// Purpose
//   Runs the base integer ops in one cycle: arithmetic, branch, JAL, JALR,
//   LUI and AUIPC. When ALU_MDU_M_EXT_EN is defined, it also runs the M ops.
//   Multiplies take MUL_CYCLES cycles. Divides use an iterative radix-2
//   restoring divider that takes XLEN+1 cycles. Divide by zero and signed
//   overflow finish in one cycle. When the macro is undefined, mext is ignored
//   and every op finishes in one cycle.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global enable; when low, all state is frozen
//   rollback            flush; same effect as rst
//   in_valid/in_ready   op handshake with the reservation station
//   opcode, func3, func1, mext, val1, val2, imm, pc, rob_pos   op fields
//   out_valid/out_ready result handshake with the CDB arbiter
//   out_rob_pos, out_val, out_jump, out_pc                     result fields
//
// Configuration macro: ALU_MDU_M_EXT_EN (undefined = base ops only).
module alu_mdu #(
    parameter int XLEN       = 32,
    parameter int ROB_POS_W  = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 func1,
    input  logic                 mext,
    input  logic [XLEN-1:0]      val1,
    input  logic [XLEN-1:0]      val2,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      pc,
    input  logic [ROB_POS_W-1:0] rob_pos,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROB_POS_W-1:0] out_rob_pos,
    output logic [XLEN-1:0]      out_val,
    output logic                 out_jump,
    output logic [XLEN-1:0]      out_pc
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ARITH  = 7'b0110011;
    localparam logic [6:0] OPC_ARITHI = 7'b0010011;

    function automatic logic branch_taken(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Base single-cycle datapath
    logic [XLEN-1:0]        op2, base_val, base_pc, pc_plus4;
    logic signed [XLEN-1:0] s1, s2;
    logic [SH_W-1:0]        shamt;
    logic                   base_jump;

    always_comb begin
        op2       = (opcode == OPC_ARITH) ? val2 : imm;
        s1        = val1;
        s2        = op2;
        shamt     = op2[SH_W-1:0];
        pc_plus4  = pc + XLEN'(4);
        base_val  = '0;
        base_jump = 1'b0;
        base_pc   = pc_plus4;
        case (opcode)
            OPC_LUI:   base_val = imm;
            OPC_AUIPC: base_val = pc + imm;
            OPC_JAL: begin
                base_val  = pc_plus4;
                base_jump = 1'b1;
                base_pc   = pc + imm;
            end
            OPC_JALR: begin
                base_val  = pc_plus4;
                base_jump = 1'b1;
                base_pc   = (val1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
            end
            OPC_BRANCH: begin
                if (branch_taken(func3, val1, val2)) begin
                    base_jump = 1'b1;
                    base_pc   = pc + imm;
                end
            end
            OPC_ARITH, OPC_ARITHI: begin
                case (func3)
                    3'b000:  base_val = (opcode == OPC_ARITH && func1) ? val1 - op2 : val1 + op2;
                    3'b001:  base_val = val1 << shamt;
                    3'b010:  base_val = {{(XLEN-1){1'b0}}, (s1 < s2)};
                    3'b011:  base_val = {{(XLEN-1){1'b0}}, (val1 < op2)};
                    3'b100:  base_val = val1 ^ op2;
                    3'b101:  base_val = func1 ? $unsigned(s1 >>> shamt) : val1 >> shamt;
                    3'b110:  base_val = val1 | op2;
                    default: base_val = val1 & op2;
                endcase
            end
            default: ;
        endcase
    end

    logic                 out_valid_q, out_valid_d, out_jump_q, out_jump_d;
    logic [ROB_POS_W-1:0] out_rob_pos_q, out_rob_pos_d;
    logic [XLEN-1:0]      out_val_q, out_val_d, out_pc_q, out_pc_d;
    logic                 out_free, accept, done, res_jump;
    logic [XLEN-1:0]      res_val, res_pc;
    logic [ROB_POS_W-1:0] res_tag;

    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef ALU_MDU_M_EXT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
    localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Product of the sign- or zero-extended operands, reduced to 2*XLEN bits.
    function automatic logic [XLEN-1:0] mul_result(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic                     a_sx, b_sx;
        logic signed [2*XLEN-1:0] ea, eb, prod;
        a_sx = (f3 == 3'b001 || f3 == 3'b010) && a[XLEN-1];
        b_sx = (f3 == 3'b001) && b[XLEN-1];
        ea   = {{XLEN{a_sx}}, a};
        eb   = {{XLEN{b_sx}}, b};
        prod = ea * eb;
        return (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           f3_q, f3_d;
    // a_q holds multiplicand, or dividend magnitude shifting into quotient bits
    logic [XLEN-1:0]      a_q, a_d, b_q, b_d, rem_q, rem_d, npc_q, npc_d;
    logic                 neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [ROB_POS_W-1:0] tag_q, tag_d;
    logic                 is_m, div_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN:0]        rem_sh, diff;
    logic [XLEN-1:0]      quo_nx, rem_nx, div_res;

    assign in_ready = rdy && (state_q == ST_IDLE) && out_free;

    always_comb begin
        done      = 1'b0;
        res_val   = base_val;
        res_jump  = base_jump;
        res_pc    = base_pc;
        res_tag   = rob_pos;
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        npc_d     = npc_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        tag_d     = tag_q;

        // One restoring step: shift in the next dividend bit, subtract if it fits.
        rem_sh = {rem_q, a_q[XLEN-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (!diff[XLEN]) begin
            rem_nx = diff[XLEN-1:0];
            quo_nx = {a_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[XLEN-1:0];
            quo_nx = {a_q[XLEN-2:0], 1'b0};
        end
        div_res = f3_q[1] ? (neg_rem_q ? -rem_nx : rem_nx) : (neg_quo_q ? -quo_nx : quo_nx);

        is_m     = (opcode == OPC_ARITH) && mext;
        div_sgn  = !func3[0];
        a_neg    = div_sgn && val1[XLEN-1];
        b_neg    = div_sgn && val2[XLEN-1];
        div_zero = (val2 == '0);
        div_ovf  = div_sgn && (val1 == {1'b1, {(XLEN-1){1'b0}}}) && (val2 == '1);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_m) begin
                        res_jump = 1'b0;
                        res_pc   = pc_plus4;
                        tag_d    = rob_pos;
                        npc_d    = pc_plus4;
                        f3_d     = func3;
                        if (!func3[2]) begin
                            if (MUL_CYCLES == 1) begin
                                done    = 1'b1;
                                res_val = mul_result(func3, val1, val2);
                            end else begin
                                a_d     = val1;
                                b_d     = val2;
                                cnt_d   = CNT_W'(1);
                                state_d = ST_MUL;
                            end
                        end else if (div_zero) begin
                            done    = 1'b1;
                            res_val = func3[1] ? val1 : '1;
                        end else if (div_ovf) begin
                            done    = 1'b1;
                            res_val = func3[1] ? '0 : val1;
                        end else begin
                            a_d       = a_neg ? -val1 : val1;
                            b_d       = b_neg ? -val2 : val2;
                            rem_d     = '0;
                            neg_quo_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            cnt_d     = '0;
                            state_d   = ST_DIV;
                        end
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                res_val  = mul_result(f3_q, a_q, b_q);
                res_jump = 1'b0;
                res_pc   = npc_q;
                res_tag  = tag_q;
                if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                    if (out_free) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DIV: begin
                res_val  = div_res;
                res_jump = 1'b0;
                res_pc   = npc_q;
                res_tag  = tag_q;
                // The last iteration is folded into the write, so it waits for output space.
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    if (out_free) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    a_d   = quo_nx;
                    rem_d = rem_nx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
`else
    logic unused_mext;
    assign unused_mext = mext;
    assign in_ready    = rdy && out_free;

    always_comb begin
        done     = accept;
        res_val  = base_val;
        res_jump = base_jump;
        res_pc   = base_pc;
        res_tag  = rob_pos;
    end
`endif

    // Output register: load on completion; otherwise drain when the CDB takes it.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_val_d     = out_val_q;
        out_jump_d    = out_jump_q;
        out_pc_d      = out_pc_q;
        out_rob_pos_d = out_rob_pos_q;
        if (done) begin
            out_valid_d   = 1'b1;
            out_val_d     = res_val;
            out_jump_d    = res_jump;
            out_pc_d      = res_pc;
            out_rob_pos_d = res_tag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            out_valid_q   <= 1'b0;
            out_val_q     <= '0;
            out_jump_q    <= 1'b0;
            out_pc_q      <= '0;
            out_rob_pos_q <= '0;
`ifdef ALU_MDU_M_EXT_EN
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
`endif
        end else if (rdy) begin
            out_valid_q   <= out_valid_d;
            out_val_q     <= out_val_d;
            out_jump_q    <= out_jump_d;
            out_pc_q      <= out_pc_d;
            out_rob_pos_q <= out_rob_pos_d;
`ifdef ALU_MDU_M_EXT_EN
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            f3_q          <= f3_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rem_q         <= rem_d;
            npc_q         <= npc_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            tag_q         <= tag_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign out_val     = out_val_q;
    assign out_jump    = out_jump_q;
    assign out_pc      = out_pc_q;
    assign out_rob_pos = out_rob_pos_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu (XLEN=32, ROB_POS_W=4, MUL_CYCLES=3).
// Reference model derived from RV32I/M semantics; works with or without ALU_MDU_M_EXT_EN.
module tb_alu_mdu;
    localparam int MULC = 3;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;
`ifdef ALU_MDU_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, in_valid, in_ready, func1, mext;
    logic        out_valid, out_ready, out_jump;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] val1, val2, imm, pc, out_val, out_pc;
    logic [3:0]  rob_pos, out_rob_pos;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(32), .ROB_POS_W(4), .MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .func1(func1), .mext(mext),
        .val1(val1), .val2(val2), .imm(imm), .pc(pc), .rob_pos(rob_pos),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob_pos(out_rob_pos),
        .out_val(out_val), .out_jump(out_jump), .out_pc(out_pc)
    );

    // Reference model: result, jump, next pc and latency of one op.
    task automatic model(input logic [6:0] opc, input logic [2:0] f3, input logic f1, input logic m,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] p, output logic [31:0] v, output logic j,
                         output logic [31:0] np, output int lat);
        logic [31:0] o2;
        int sa, sb, so2, sh;
        longint prod;
        longint unsigned uprod;
        bit t, ovf;
        o2  = (opc == OP_ARITH) ? b : im;
        sa  = a;
        sb  = b;
        so2 = o2;
        sh  = int'(o2[4:0]);
        v   = 32'd0;
        j   = 1'b0;
        np  = p + 32'd4;
        lat = 1;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (opc == OP_ARITH && m && M_EN) begin
            case (f3)
                3'd0: begin v = a * b; lat = MULC; end
                3'd1: begin prod = longint'(sa) * longint'(sb); v = prod[63:32]; lat = MULC; end
                3'd2: begin prod = longint'(sa) * longint'(b); v = prod[63:32]; lat = MULC; end
                3'd3: begin uprod = 64'(a) * 64'(b); v = uprod[63:32]; lat = MULC; end
                3'd4: begin
                    if (b == 0) v = 32'hFFFF_FFFF;
                    else if (ovf) v = a;
                    else begin v = sa / sb; lat = 33; end
                end
                3'd5: begin
                    if (b == 0) v = 32'hFFFF_FFFF;
                    else begin v = a / b; lat = 33; end
                end
                3'd6: begin
                    if (b == 0) v = a;
                    else if (ovf) v = 32'd0;
                    else begin v = sa % sb; lat = 33; end
                end
                default: begin
                    if (b == 0) v = a;
                    else begin v = a % b; lat = 33; end
                end
            endcase
        end else begin
            case (opc)
                OP_LUI:   v = im;
                OP_AUIPC: v = p + im;
                OP_JAL:   begin v = p + 32'd4; j = 1'b1; np = p + im; end
                OP_JALR:  begin v = p + 32'd4; j = 1'b1; np = (a + im) & 32'hFFFF_FFFE; end
                OP_BRANCH: begin
                    case (f3)
                        3'd0: t = (a == b);
                        3'd1: t = (a != b);
                        3'd4: t = (sa < sb);
                        3'd5: t = (sa >= sb);
                        3'd6: t = (a < b);
                        3'd7: t = (a >= b);
                        default: t = 1'b0;
                    endcase
                    if (t) begin j = 1'b1; np = p + im; end
                end
                default: begin
                    case (f3)
                        3'd0: v = (opc == OP_ARITH && f1) ? a - o2 : a + o2;
                        3'd1: v = a << sh;
                        3'd2: v = (sa < so2) ? 32'd1 : 32'd0;
                        3'd3: v = (a < o2) ? 32'd1 : 32'd0;
                        3'd4: v = a ^ o2;
                        3'd5: v = f1 ? 32'(sa >>> sh) : a >> sh;
                        3'd6: v = a | o2;
                        default: v = a & o2;
                    endcase
                end
            endcase
        end
    endtask

    // Present one op with out_ready=1, wait for acceptance and for its result.
    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic f1,
                          input logic m, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] p, input logic [3:0] tag,
                          output logic [31:0] v, output logic j, output logic [31:0] np,
                          output logic [3:0] t, output int lat, output logic busy_rdy);
        int w;
        opcode = opc; func3 = f3; func1 = f1; mext = m;
        val1 = a; val2 = b; imm = im; pc = p; rob_pos = tag;
        out_ready = 1'b1;
        in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk); #1; w++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        val1 = $urandom; val2 = $urandom; imm = $urandom; pc = $urandom; rob_pos = 4'($urandom);
        @(negedge clk);
        busy_rdy = in_ready;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk); lat++;
        end
        if (!out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
        end
        v = out_val; j = out_jump; np = out_pc; t = out_rob_pos;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; out_ready = 1'b1;
        opcode = OP_ARITH; func3 = 3'd0; func1 = 1'b0; mext = 1'b0;
        val1 = 32'd1; val2 = 32'd2; imm = 32'd0; pc = 32'h10; rob_pos = 4'd5; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_val !== 32'd0) begin n_bad++; $display("FAIL reset_val: got %h want 0", out_val); end
        n_cmp++; if (out_rob_pos !== 4'd0) begin n_bad++; $display("FAIL reset_tag: got %0d want 0", out_rob_pos); end
        n_cmp++; if (out_jump !== 1'b0 || out_pc !== 32'd0) begin n_bad++; $display("FAIL reset_jump_pc: got %0b/%h want 0/0", out_jump, out_pc); end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got out_valid %0b want 0", out_valid); end
    endtask

    task automatic check_op(input string name, input logic [6:0] opc, input logic [2:0] f3,
                            input logic f1, input logic m, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                            input logic [3:0] tag);
        logic [31:0] v, np, ev, enp;
        logic j, ej, busy;
        logic [3:0] t;
        int lat, elat;
        model(opc, f3, f1, m, a, b, im, p, ev, ej, enp, elat);
        run_op(opc, f3, f1, m, a, b, im, p, tag, v, j, np, t, lat, busy);
        n_cmp++;
        if ({v, j, np, t} !== {ev, ej, enp, tag} || lat != elat) begin
            n_bad++;
            $display("FAIL %s: got val=%h jump=%0b pc=%h tag=%0d lat=%0d want val=%h jump=%0b pc=%h tag=%0d lat=%0d",
                     name, v, j, np, t, lat, ev, ej, enp, tag, elat);
        end
        n_cmp++;
        if (busy !== (elat == 1)) begin
            n_bad++;
            $display("FAIL %s_in_ready: got %0b after accept want %0b", name, busy, (elat == 1));
        end
    endtask

    task automatic test_add();
        check_op("add_5_7", OP_ARITH, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h40, 4'd3);
        check_op("sub", OP_ARITH, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0, 32'h44, 4'd4);
        check_op("srai", OP_ARITHI, 3'd5, 1'b1, 1'b0, 32'h8000_0010, 32'd0, 32'd4, 32'h48, 4'd5);
    endtask

    task automatic test_branch();
        check_op("blt", OP_BRANCH, 3'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd6);
        check_op("bltu", OP_BRANCH, 3'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd7);
        check_op("branch_undef", OP_BRANCH, 3'd2, 1'b0, 1'b0, 32'd1, 32'd1, 32'h20, 32'h100, 4'd8);
        check_op("jalr", OP_JALR, 3'd0, 1'b0, 1'b0, 32'h1001, 32'd0, 32'h10, 32'h200, 4'd9);
    endtask

    task automatic test_mext();
        check_op("mulh", OP_ARITH, 3'd1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h300, 4'd1);
        check_op("mulhu", OP_ARITH, 3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h304, 4'd2);
        check_op("div_m7_2", OP_ARITH, 3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h308, 4'd3);
        check_op("rem_m7_2", OP_ARITH, 3'd6, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h30C, 4'd4);
        check_op("divu_by0", OP_ARITH, 3'd5, 1'b0, 1'b1, 32'd9, 32'd0, 32'd0, 32'h310, 4'd5);
        check_op("div_ovf", OP_ARITH, 3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h314, 4'd6);
    endtask

    task automatic test_random(input int n);
        logic [6:0] opc;
        logic [2:0] f3;
        logic f1, m;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0: opc = OP_LUI;
                1: opc = OP_AUIPC;
                2: opc = OP_JAL;
                3: opc = OP_JALR;
                4: opc = OP_BRANCH;
                5: opc = OP_ARITHI;
                default: opc = OP_ARITH;
            endcase
            f3 = 3'($urandom);
            f1 = 1'($urandom);
            m  = 1'($urandom);
            check_op($sformatf("random_%0d", i), opc, f3, f1, m, rand_val(), rand_val(),
                     rand_val(), $urandom & 32'hFFFF_FFFC, 4'($urandom));
        end
    endtask

    task automatic test_stall();
        logic [31:0] ev, enp, sv, snp;
        logic ej, sj;
        logic [3:0] st;
        int elat, w;
        idle(1);
        opcode = OP_ARITH; func3 = 3'd0; func1 = 1'b0; mext = 1'b0;
        val1 = 32'd100; val2 = 32'd23; imm = 32'd0; pc = 32'h500; rob_pos = 4'd11;
        out_ready = 1'b0; in_valid = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_accept: in_ready=%0b want 1", in_ready); end
        @(posedge clk); #1;
        // Next op (XOR) waits behind the stalled result.
        func3 = 3'd4; val1 = 32'hF0F0_1234; val2 = 32'h0FF0_4321; pc = 32'h504; rob_pos = 4'd12;
        @(negedge clk);
        model(OP_ARITH, 3'd0, 1'b0, 1'b0, 32'd100, 32'd23, 32'd0, 32'h500, ev, ej, enp, elat);
        sv = out_val; sj = out_jump; snp = out_pc; st = out_rob_pos;
        n_cmp++;
        if ({out_valid, sv, sj, snp, st} !== {1'b1, ev, ej, enp, 4'd11}) begin
            n_bad++;
            $display("FAIL stall_result: got v=%0b val=%h pc=%h tag=%0d want 1 %h %h 11", out_valid, sv, snp, st, ev, enp);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_val, out_jump, out_pc, out_rob_pos, in_ready} !== {1'b1, sv, sj, snp, st, 1'b0}) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: got v=%0b val=%h tag=%0d in_ready=%0b want 1 %h %0d 0",
                         k, out_valid, out_val, out_rob_pos, in_ready, sv, st);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: in_ready=%0b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        model(OP_ARITH, 3'd4, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_4321, 32'd0, 32'h504, ev, ej, enp, elat);
        n_cmp++;
        if ({out_valid, out_val, out_pc, out_rob_pos} !== {1'b1, ev, enp, 4'd12}) begin
            n_bad++;
            $display("FAIL stall_next: got v=%0b val=%h pc=%h tag=%0d want 1 %h %h 12", out_valid, out_val, out_pc, out_rob_pos, ev, enp);
        end
        idle(1);
    endtask

    task automatic test_rdy();
        logic [31:0] held;
        idle(1);
        opcode = OP_ARITH; func3 = 3'd6; func1 = 1'b0; mext = 1'b0;
        val1 = 32'h0000_00F0; val2 = 32'h0000_000F; pc = 32'h600; rob_pos = 4'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rdy = 1'b0;
        @(negedge clk);
        held = out_val;
        n_cmp++; if (out_valid !== 1'b1 || held !== 32'h0000_00FF) begin n_bad++; $display("FAIL rdy_result: got %0b/%h want 1/000000ff", out_valid, held); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_val, in_ready} !== {1'b1, held, 1'b0}) begin
            n_bad++;
            $display("FAIL rdy_freeze: got v=%0b val=%h in_ready=%0b want 1 %h 0", out_valid, out_val, in_ready, held);
        end
        rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rdy_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_rollback_output();
        idle(1);
        opcode = OP_LUI; func3 = 3'd0; func1 = 1'b0; mext = 1'b0;
        imm = 32'h1234_5000; pc = 32'h700; rob_pos = 4'd13; out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_val !== 32'h1234_5000) begin n_bad++; $display("FAIL rb_out_result: got %0b/%h want 1/12345000", out_valid, out_val); end
        rollback = 1'b1;
        @(posedge clk); #1;
        rollback = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL rb_out_flush: got out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
        end
        idle(1);
    endtask

`ifdef ALU_MDU_M_EXT_EN
    task automatic test_rollback_div();
        bit seen;
        idle(1);
        opcode = OP_ARITH; func3 = 3'd4; func1 = 1'b0; mext = 1'b1;
        val1 = 32'd1000; val2 = 32'd7; pc = 32'h800; rob_pos = 4'd14; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1; rollback = 1'b1;
        @(posedge clk); #1;
        rollback = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL rb_div_idle: got out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL rb_div_noresult: result appeared=%0b want 0", seen); end
        check_op("after_rollback", OP_ARITH, 3'd5, 1'b0, 1'b1, 32'd1000, 32'd7, 32'd0, 32'h804, 4'd15);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_mext();
        test_stall();
        test_rdy();
        test_rollback_output();
`ifdef ALU_MDU_M_EXT_EN
        test_rollback_div();
`endif
        test_random(80);
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
